// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Purpose  : 16x8 first-word-fall-through FIFO for the UART TX/RX paths, with
//            overrun/underrun flags and a programmable fill-level trigger.
//            Define FIFO_STICKY_ERR_EN to make over_run/under_run sticky.
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic              over_run,
  output logic              under_run,
  input  logic [ADDR_W-1:0] threshold,
  output logic              thre_trigger
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              over_run_q, over_run_d;
  logic              under_run_q, under_run_d;

  logic wr_ok;
  logic rd_ok;
  logic ovr_evt;
  logic unr_evt;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));

  // A pop frees a slot in the same edge, so push while full is still taken.
  assign wr_ok   = en & push_in & (~full | pop_in);
  assign rd_ok   = en & pop_in & ~empty;
  assign ovr_evt = en & push_in & full & ~pop_in;
  assign unr_evt = en & pop_in & empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
`ifdef FIFO_STICKY_ERR_EN
    over_run_d  = over_run_q | ovr_evt;
    under_run_d = under_run_q | unr_evt;
`else
    over_run_d  = ovr_evt;
    under_run_d = unr_evt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      over_run_q  <= 1'b0;
      under_run_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      over_run_q  <= over_run_d;
      under_run_q <= under_run_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout         = mem_q[rd_ptr_q];
  assign over_run     = over_run_q;
  assign under_run    = under_run_q;
  assign thre_trigger = (threshold != '0) && (count_q >= {1'b0, threshold});

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo
// Purpose  : Self-checking bench for fifo against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       push_in;
  logic       pop_in;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       over_run;
  logic       under_run;
  logic [3:0] threshold;
  logic       thre_trigger;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic       exp_ovr;
  logic       exp_unr;

  fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .push_in      (push_in),
    .pop_in       (pop_in),
    .din          (din),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .over_run     (over_run),
    .under_run    (under_run),
    .threshold    (threshold),
    .thre_trigger (thre_trigger)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("over_run", 32'(over_run), 32'(exp_ovr));
    chk("under_run", 32'(under_run), 32'(exp_unr));
    chk("thre_trigger", 32'(thre_trigger), 32'((threshold != 4'd0) && (n >= int'(threshold))));
    if (n != 0) chk("dout", 32'(dout), 32'(model_q[0]));
  endtask

  // One clock of stimulus; the model applies the acceptance rules then checks.
  task automatic step(input logic e, input logic p, input logic q, input logic [7:0] d);
    bit was_full, was_empty, wr, rd, ovr_ev, unr_ev;
    en = e; push_in = p; pop_in = q; din = d;
    was_full  = (model_q.size() == 16);
    was_empty = (model_q.size() == 0);
    wr     = e && p && (!was_full || q);
    rd     = e && q && !was_empty;
    ovr_ev = e && p && was_full && !q;
    unr_ev = e && q && was_empty;
    @(posedge clk); #1;
    if (rd) void'(model_q.pop_front());
    if (wr) model_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
    exp_ovr = exp_ovr | ovr_ev;
    exp_unr = exp_unr | unr_ev;
`else
    exp_ovr = ovr_ev;
    exp_unr = unr_ev;
`endif
    check_all();
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_ovr = 1'b0;
    exp_unr = 1'b0;
  endtask

  initial begin
    logic [7:0] pushed[$];
    logic [7:0] b;
    rst = 1'b1; en = 1'b0; push_in = 1'b0; pop_in = 1'b0; din = 8'h00; threshold = 4'h0;
    model_reset();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_dout", 32'(dout), 32'h0);
    check_all();

    // Fill past full with trigger at 10.
    threshold = 4'hA;
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      pushed.push_back(b);
      step(1'b1, 1'b1, 1'b0, b);
    end
    chk("full_head", 32'(dout), 32'(pushed[0]));

    // Drain completely, then one extra pop.
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(dout), 32'(pushed[i]));
      step(1'b1, 1'b0, 1'b1, 8'h00);
    end
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Simultaneous push+pop while empty, then at 5 entries.
    step(1'b1, 1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom));
    chk("simul5_count", 32'(model_q.size()), 32'd5);

    // Simultaneous push+pop while full.
    while (model_q.size() < 16) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom));

    // Disabled: nothing moves.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom));

    // Random traffic with changing threshold.
    for (int i = 0; i < 400; i++) begin
      if ((i % 37) == 0) threshold = 4'($urandom);
      step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Asynchronous reset mid-stream.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    while (model_q.size() > 0) step(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    en = 1'b0; push_in = 1'b0; pop_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_empty", 32'(empty), 32'h1);
    chk("async_rst_dout", 32'(dout), 32'h0);
    check_all();
    @(posedge clk); #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    chk("post_rst_dout", 32'(dout), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
